nvme_ctrl_enable_fsm: RTL and testbench

//   Controller enable/shutdown sequencer downstream of the NVMe register file.

---
 rtl/nvme_ctrl_pkg.sv | 36 +++
 rtl/nvme_timeout_timer.sv | 57 +++++
 rtl/nvme_ctrl_enable_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_nvme_ctrl_enable_fsm.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/nvme_ctrl_pkg.sv
// nvme_ctrl_pkg
//    Shared definitions for the NVMe controller enable/shutdown sequencer:
//    the sequencer state enum, CC and CSTS bit positions, SHST encodings and
//    the saturation value of the timeout unit counter.
package nvme_ctrl_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_DISABLED = 3'd0,
      ST_INIT     = 3'd1,
      ST_READY    = 3'd2,
      ST_SHDN     = 3'd3,
      ST_TEARDOWN = 3'd4,
      ST_FAULT    = 3'd5
   } ctrlState_e;

   // CC field positions
   localparam int CC_EN      = 0;
   localparam int CC_SHN_HI  = 15;
   localparam int CC_SHN_LO  = 14;

   // CSTS field positions
   localparam int CSTS_RDY     = 0;
   localparam int CSTS_CFS     = 1;
   localparam int CSTS_SHST_LO = 2;
   localparam int CSTS_SHST_HI = 3;

   // CSTS.SHST encodings
   localparam logic [1:0] SHST_NORMAL = 2'b00;
   localparam logic [1:0] SHST_OCCUR  = 2'b01;
   localparam logic [1:0] SHST_CMPLT  = 2'b10;

   // The timeout unit counter stops counting here
   localparam logic [7:0] UNIT_MAX = 8'hFF;

endpackage

// File: rtl/nvme_timeout_timer.sv
// nvme_timeout_timer
//    Bring-up timeout timer. A prescaler divides clk by TICK_CYCLES to make
//    one timeout unit (500 ms in the real system). An 8-bit unit counter
//    counts those units and holds at 255.
//    The whole module is compiled only when NVME_CTRL_TIMEOUT_EN is defined.
//    It is the only build that instantiates it, so the default build does
//    not carry an unused module.
// Ports
//    clk      in   1  rising-edge clock
//    reset    in   1  synchronous active-high reset
//    clear    in   1  zero the prescaler and the unit counter
//    enable   in   1  advance the prescaler
//    limit    in   8  unit count that means the timeout has expired
//    expired  out  1  enable is high and the unit count equals limit
`ifdef NVME_CTRL_TIMEOUT_EN
module nvme_timeout_timer
   import nvme_ctrl_pkg::*;
#(
   parameter int TICK_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] limit,
   output logic       expired
);

   localparam int PRESCALE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICK_CYCLES - 1);

   logic [PRESCALE_W-1:0] prescaleCount;
   logic [7:0]            unitCount;

   // The prescaler wraps every TICK_CYCLES enabled cycles.
   // Each wrap adds one unit, and the unit count stops at UNIT_MAX
   // so it cannot roll back under the limit.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         prescaleCount <= '0;
         unitCount     <= '0;
      end else if (enable) begin
         if (prescaleCount == PRESCALE_LAST) begin
            prescaleCount <= '0;
            if (unitCount != UNIT_MAX) begin
               unitCount <= unitCount + 8'd1;
            end
         end else begin
            prescaleCount <= prescaleCount + 1'b1;
         end
      end
   end

   assign expired = enable && (unitCount == limit);

endmodule
`endif

// File: rtl/nvme_ctrl_enable_fsm.sv
// nvme_ctrl_enable_fsm
//    Controller enable and shutdown sequencer. It sits downstream of the NVMe
//    register file. It follows CC.EN and CC.SHN, handshakes with the backend
//    bring-up, teardown and shutdown logic, and builds the registered CSTS
//    word (RDY, CFS, SHST).
//    Optional feature: define NVME_CTRL_TIMEOUT_EN to fault the controller
//    when bring-up takes longer than CAP.TO units of TICK_CYCLES clocks.
// Ports
//    clk             in   1   rising-edge clock
//    reset           in   1   synchronous active-high reset
//    cc              in   32  live CC register (EN = bit 0, SHN = bits 15:14)
//    cap_to          in   8   CAP.TO, bring-up timeout in units
//    init_done       in   1   backend bring-up finished
//    teardown_done   in   1   backend teardown finished
//    shdn_done       in   1   backend shutdown processing finished
//    fatal_err       in   1   backend fatal error level
//    csts            out  32  {28'b0, SHST, CFS, RDY}
//    init_start      out  1   one-cycle pulse that starts bring-up
//    teardown_start  out  1   one-cycle pulse that starts teardown
//    shdn_start      out  1   one-cycle pulse that starts shutdown
module nvme_ctrl_enable_fsm
   import nvme_ctrl_pkg::*;
#(
   parameter int TICK_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cc,
   input  logic [7:0]  cap_to,
   input  logic        init_done,
   input  logic        teardown_done,
   input  logic        shdn_done,
   input  logic        fatal_err,
   output logic [31:0] csts,
   output logic        init_start,
   output logic        teardown_start,
   output logic        shdn_start
);

   ctrlState_e state, stateNext;
   logic       rdyReg, rdyNext;
   logic       cfsReg, cfsNext;
   logic [1:0] shstReg, shstNext;
   logic       initStartNext, teardownStartNext, shdnStartNext;
   logic       ccEn;
   logic [1:0] ccShn;
   logic       timeoutExpired;
   logic       unusedCcBits;

   assign ccEn         = cc[CC_EN];
   assign ccShn        = cc[CC_SHN_HI:CC_SHN_LO];
   assign unusedCcBits = ^{cc[31:16], cc[13:1]};

`ifdef NVME_CTRL_TIMEOUT_EN
   logic [7:0] unitLimit;

   // Capture CAP.TO as INIT is entered, so a later change to CAP.TO cannot
   // move the deadline. A CAP.TO of zero still allows one unit.
   always_ff @(posedge clk) begin
      if (reset) begin
         unitLimit <= 8'd1;
      end else if ((state != ST_INIT) && (stateNext == ST_INIT)) begin
         unitLimit <= (cap_to == 8'd0) ? 8'd1 : cap_to;
      end
   end

   // The timer runs only in INIT and is held clear in every other state.
   nvme_timeout_timer #(
      .TICK_CYCLES (TICK_CYCLES)
   ) timeoutTimer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state != ST_INIT),
      .enable  (state == ST_INIT),
      .limit   (unitLimit),
      .expired (timeoutExpired)
   );
`else
   localparam int unusedTickCycles = TICK_CYCLES;
   logic unusedCapTo;

   assign unusedCapTo    = ^cap_to;
   assign timeoutExpired = 1'b0;
`endif

   // Next-state and next-output logic. The conditions are checked in
   // priority order: fatal_err, then EN == 0, then the done handshake,
   // then the SHN request. CSTS fields hold their value unless a transition
   // changes them. At most one start pulse is raised per cycle.
   always_comb begin
      stateNext         = state;
      rdyNext           = rdyReg;
      cfsNext           = cfsReg;
      shstNext          = shstReg;
      initStartNext     = 1'b0;
      teardownStartNext = 1'b0;
      shdnStartNext     = 1'b0;
      case (state)
         ST_DISABLED: begin
            rdyNext = 1'b0;
            if (ccEn && !cfsReg) begin
               stateNext     = ST_INIT;
               initStartNext = 1'b1;
            end
         end
         ST_INIT: begin
            if (fatal_err) begin
               stateNext = ST_FAULT;
               cfsNext   = 1'b1;
               rdyNext   = 1'b0;
            end else if (!ccEn) begin
               stateNext         = ST_TEARDOWN;
               teardownStartNext = 1'b1;
            end else if (init_done) begin
               stateNext = ST_READY;
               rdyNext   = 1'b1;
            end else if (timeoutExpired) begin
               stateNext = ST_FAULT;
               cfsNext   = 1'b1;
               rdyNext   = 1'b0;
            end
         end
         ST_READY: begin
            if (fatal_err) begin
               stateNext = ST_FAULT;
               cfsNext   = 1'b1;
               rdyNext   = 1'b0;
            end else if (!ccEn) begin
               stateNext         = ST_TEARDOWN;
               teardownStartNext = 1'b1;
            end else if ((ccShn != 2'b00) && (shstReg == SHST_NORMAL)) begin
               stateNext     = ST_SHDN;
               shstNext      = SHST_OCCUR;
               shdnStartNext = 1'b1;
            end
         end
         ST_SHDN: begin
            if (fatal_err) begin
               stateNext = ST_FAULT;
               cfsNext   = 1'b1;
               rdyNext   = 1'b0;
            end else if (!ccEn) begin
               stateNext         = ST_TEARDOWN;
               teardownStartNext = 1'b1;
            end else if (shdn_done) begin
               stateNext = ST_READY;
               shstNext  = SHST_CMPLT;
            end
         end
         ST_TEARDOWN: begin
            if (fatal_err) begin
               cfsNext = 1'b1;
            end else if (teardown_done) begin
               stateNext = ST_DISABLED;
               rdyNext   = 1'b0;
               cfsNext   = 1'b0;
               shstNext  = SHST_NORMAL;
            end
         end
         ST_FAULT: begin
            cfsNext = 1'b1;
            rdyNext = 1'b0;
            if (!ccEn) begin
               stateNext         = ST_TEARDOWN;
               teardownStartNext = 1'b1;
            end
         end
         default: begin
            stateNext = ST_DISABLED;
            rdyNext   = 1'b0;
            cfsNext   = 1'b0;
            shstNext  = SHST_NORMAL;
         end
      endcase
   end

   // State and every output are registered, so CSTS and the start pulses
   // change one clock after the condition that causes them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_DISABLED;
         rdyReg         <= 1'b0;
         cfsReg         <= 1'b0;
         shstReg        <= SHST_NORMAL;
         init_start     <= 1'b0;
         teardown_start <= 1'b0;
         shdn_start     <= 1'b0;
      end else begin
         state          <= stateNext;
         rdyReg         <= rdyNext;
         cfsReg         <= cfsNext;
         shstReg        <= shstNext;
         init_start     <= initStartNext;
         teardown_start <= teardownStartNext;
         shdn_start     <= shdnStartNext;
      end
   end

   assign csts = {28'b0, shstReg, cfsReg, rdyReg};

endmodule

// File: tb/tb_nvme_ctrl_enable_fsm.sv
// tb_nvme_ctrl_enable_fsm
//    Self-checking bench for nvme_ctrl_enable_fsm with TICK_CYCLES = 4.
//    Each stimulus cycle pushes the expected {csts, init_start,
//    teardown_start, shdn_start}. A monitor pops that value one time unit
//    after the next rising edge and compares it with the DUT outputs.
module tb_nvme_ctrl_enable_fsm;

   localparam int TICK = 4;

   typedef struct {
      string       tag;
      logic [34:0] value;
   } expEntry_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] cc = '0;
   logic [7:0]  capTo = 8'd2;
   logic        initDone = 1'b0;
   logic        teardownDone = 1'b0;
   logic        shdnDone = 1'b0;
   logic        fatalErr = 1'b0;
   logic [31:0] csts;
   logic        initStart, teardownStart, shdnStart;

   expEntry_t expQ[$];
   expEntry_t expHead;
   int        checks = 0;
   int        failures = 0;

   nvme_ctrl_enable_fsm #(.TICK_CYCLES(TICK)) dut (
      .clk            (clk),
      .reset          (reset),
      .cc             (cc),
      .cap_to         (capTo),
      .init_done      (initDone),
      .teardown_done  (teardownDone),
      .shdn_done      (shdnDone),
      .fatal_err      (fatalErr),
      .csts           (csts),
      .init_start     (initStart),
      .teardown_start (teardownStart),
      .shdn_start     (shdnStart)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and count the result
   task automatic checkOutput(input string tag, input logic [34:0] observed,
                              input logic [34:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got csts=%h pulses(i,t,s)=%b expected csts=%h pulses=%b",
                  tag, observed[34:3], observed[2:0], expected[34:3], expected[2:0]);
      end
   endtask

   // Drive one cycle of inputs on the falling edge and queue the result
   // expected after the next rising edge
   task automatic applyStimulus(input string tag, input logic rst, input logic [31:0] ccV,
                                input logic id, input logic td, input logic sd,
                                input logic fe, input logic [31:0] expCsts,
                                input logic [2:0] expPulses);
      expEntry_t e;
      @(negedge clk);
      reset        = rst;
      cc           = ccV;
      initDone     = id;
      teardownDone = td;
      shdnDone     = sd;
      fatalErr     = fe;
      e.tag        = tag;
      e.value      = {expCsts, expPulses};
      expQ.push_back(e);
   endtask

   // Scoreboard monitor: pops and checks one entry per rising edge
   always @(posedge clk) begin
      #1;
      if (expQ.size() > 0) begin
         expHead = expQ.pop_front();
         checkOutput(expHead.tag, {csts, initStart, teardownStart, shdnStart}, expHead.value);
      end
   end

   initial begin
      // Reset, with EN high while reset is asserted
      applyStimulus("reset",        1, 32'h0,    0, 0, 0, 0, 32'h0, 3'b000);
      applyStimulus("resetHoldEn",  1, 32'h1,    0, 0, 0, 0, 32'h0, 3'b000);
      applyStimulus("idle",         0, 32'h0,    0, 0, 0, 0, 32'h0, 3'b000);
      // Enable, then shutdown, then disable
      applyStimulus("enRise",       0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b100);
      applyStimulus("initWait",     0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b000);
      applyStimulus("initDone",     0, 32'h1,    1, 0, 0, 0, 32'h1, 3'b000);
      applyStimulus("readyIgnId",   0, 32'h1,    1, 0, 0, 0, 32'h1, 3'b000);
      applyStimulus("shnReq",       0, 32'h4001, 0, 0, 0, 0, 32'h5, 3'b001);
      applyStimulus("shdnWait",     0, 32'h4001, 0, 0, 0, 0, 32'h5, 3'b000);
      applyStimulus("shdnIgnId",    0, 32'h4001, 1, 0, 0, 0, 32'h5, 3'b000);
      applyStimulus("shdnDone",     0, 32'h4001, 0, 0, 1, 0, 32'h9, 3'b000);
      applyStimulus("shnCmplt",     0, 32'h4001, 0, 0, 0, 0, 32'h9, 3'b000);
      applyStimulus("disable",      0, 32'h0,    0, 0, 0, 0, 32'h9, 3'b010);
      applyStimulus("tdWait",       0, 32'h0,    0, 0, 0, 0, 32'h9, 3'b000);
      applyStimulus("tdDone",       0, 32'h0,    0, 1, 0, 0, 32'h0, 3'b000);
      applyStimulus("disabledIdle", 0, 32'h0,    0, 0, 0, 0, 32'h0, 3'b000);
      // Fatal error from READY
      applyStimulus("fEnRise",      0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b100);
      applyStimulus("fInitDone",    0, 32'h1,    1, 0, 0, 0, 32'h1, 3'b000);
      applyStimulus("fatal",        0, 32'h1,    0, 0, 0, 1, 32'h2, 3'b000);
      applyStimulus("faultHold",    0, 32'h1,    0, 0, 0, 0, 32'h2, 3'b000);
      applyStimulus("faultIgnDone", 0, 32'h1,    1, 0, 1, 0, 32'h2, 3'b000);
      applyStimulus("faultDisable", 0, 32'h0,    0, 0, 0, 0, 32'h2, 3'b010);
      applyStimulus("faultTdDone",  0, 32'h0,    0, 1, 0, 0, 32'h0, 3'b000);
      // EN drop and SHN set in the same cycle
      applyStimulus("pEnRise",      0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b100);
      applyStimulus("pInitDone",    0, 32'h1,    1, 0, 0, 0, 32'h1, 3'b000);
      applyStimulus("enDropShn",    0, 32'h4000, 0, 0, 0, 0, 32'h1, 3'b010);
      applyStimulus("pTdDone",      0, 32'h0,    0, 1, 0, 0, 32'h0, 3'b000);
      // Disable during INIT
      applyStimulus("iEnRise",      0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b100);
      applyStimulus("initDisable",  0, 32'h0,    0, 0, 0, 0, 32'h0, 3'b010);
      applyStimulus("iTdDone",      0, 32'h0,    0, 1, 0, 0, 32'h0, 3'b000);
      // Fatal error during TEARDOWN sets only CFS
      applyStimulus("tEnRise",      0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b100);
      applyStimulus("tInitDone",    0, 32'h1,    1, 0, 0, 0, 32'h1, 3'b000);
      applyStimulus("tDisable",     0, 32'h0,    0, 0, 0, 0, 32'h1, 3'b010);
      applyStimulus("tdFatal",      0, 32'h0,    0, 0, 0, 1, 32'h3, 3'b000);
      applyStimulus("tdFatalDone",  0, 32'h0,    0, 1, 0, 0, 32'h0, 3'b000);
      // Fatal error in DISABLED is ignored
      applyStimulus("disFatal",     0, 32'h0,    0, 0, 0, 1, 32'h0, 3'b000);
      // Reset while in SHDN
      applyStimulus("rEnRise",      0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b100);
      applyStimulus("rInitDone",    0, 32'h1,    1, 0, 0, 0, 32'h1, 3'b000);
      applyStimulus("rShnReq",      0, 32'h4001, 0, 0, 0, 0, 32'h5, 3'b001);
      applyStimulus("resetInShdn",  1, 32'h4001, 0, 0, 0, 0, 32'h0, 3'b000);
      applyStimulus("afterReset",   0, 32'h0,    0, 0, 0, 0, 32'h0, 3'b000);
      // Bring-up without init_done
      applyStimulus("toEnRise",     0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b100);
`ifdef NVME_CTRL_TIMEOUT_EN
      // CAP.TO = 2 units of 4 clocks: CFS appears on the ninth edge after INIT entry
      for (int i = 0; i < 2 * TICK; i++) begin
         applyStimulus("toWait",    0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b000);
      end
      applyStimulus("toExpired",    0, 32'h1,    0, 0, 0, 0, 32'h2, 3'b000);
      applyStimulus("toLateDone",   0, 32'h1,    1, 0, 0, 0, 32'h2, 3'b000);
      applyStimulus("toDisable",    0, 32'h0,    0, 0, 0, 0, 32'h2, 3'b010);
      applyStimulus("toTdDone",     0, 32'h0,    0, 1, 0, 0, 32'h0, 3'b000);
`else
      // Without the timer, INIT waits for init_done however long it takes
      for (int i = 0; i < 6 * TICK; i++) begin
         applyStimulus("noToWait",  0, 32'h1,    0, 0, 0, 0, 32'h0, 3'b000);
      end
      applyStimulus("noToDone",     0, 32'h1,    1, 0, 0, 0, 32'h1, 3'b000);
`endif
      // Let the monitor pop the last entry
      @(posedge clk);
      #3;
      if (expQ.size() != 0) begin
         checkOutput("queueDrain", 35'(expQ.size()), 35'd0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
